klokje_lock_seq: RTL

Lock sequencer that sits on the consuming side of the `klokje` PLL. It drives the PLL reset, watches the PLL `locked` indication, and releases downstream logic only after lock has been stable for a qualified interval. It re-runs the PLL reset on lock loss or lock timeout, and keeps sticky diagnostic status. Runs entirely in the PLL reference-clock domain; consumers in other domains synchronize `sys_rst` locally.

---
 rtl/klokje_lock_seq_if.sv | 18 +
 rtl/klokje_lock_seq.sv | 100 ++++++++++
 2 files changed

// File: rtl/klokje_lock_seq_if.sv
// klokje_lock_seq_if: PLL lock/status bundle between the lock sequencer and its environment
interface klokje_lock_seq_if;
    logic       locked;
    logic       pll_rst;
    logic       ready;
    logic       sys_rst;
    logic       timeout_err;
    logic [7:0] relock_count;
    logic [1:0] state;
    modport master (
        output locked,
        input  pll_rst, ready, sys_rst, timeout_err, relock_count, state
    );
    modport slave (
        input  locked,
        output pll_rst, ready, sys_rst, timeout_err, relock_count, state
    );
endinterface

// File: rtl/klokje_lock_seq.sv
// klokje_lock_seq: PLL reset/lock qualification sequencer with sticky diagnostics
module klokje_lock_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int SYNC_STAGES   = 2
) (
    input logic              refclk,
    input logic              rst,
    klokje_lock_seq_if.slave bus
);
    localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAXC   = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        SETTLE    = 2'd2,
        RUN       = 2'd3
    } state_t;
    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    state_t                 w_next;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt;
    logic                   w_tmo;
    logic                   w_relock;
    logic                   w_locked_s;
    logic                   r_timeout_err;
    logic [7:0]             r_relock_count;
    logic                   r_pll_rst;
    logic                   r_ready;
    assign w_locked_s = r_sync[SYNC_STAGES-1];
    // bring the asynchronous PLL lock flag into the refclk domain
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], bus.locked};
    end
    // next state, shared counter and diagnostic events; lock checks win over terminal counts
    always_comb begin
        w_next   = r_state;
        w_cnt    = r_cnt;
        w_tmo    = 1'b0;
        w_relock = 1'b0;
        case (r_state)
            PLL_RST: begin
                if (r_cnt == RST_LAST) w_next = WAIT_LOCK;
                else                   w_cnt  = r_cnt + 1'b1;
            end
            WAIT_LOCK: begin
                if (w_locked_s)             w_next = SETTLE;
                else if (r_cnt == TMO_LAST) begin
                    w_next = PLL_RST;
                    w_tmo  = 1'b1;
                end
                else                        w_cnt  = r_cnt + 1'b1;
            end
            SETTLE: begin
                if (!w_locked_s)               w_next = WAIT_LOCK;
                else if (r_cnt == STABLE_LAST) w_next = RUN;
                else                           w_cnt  = r_cnt + 1'b1;
            end
            default: begin
                if (!w_locked_s) begin
                    w_next   = PLL_RST;
                    w_relock = 1'b1;
                end
            end
        endcase
        if (w_next != r_state) w_cnt = '0;
    end
    // state, counter, sticky status and registered outputs
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state        <= PLL_RST;
            r_cnt          <= '0;
            r_timeout_err  <= 1'b0;
            r_relock_count <= 8'd0;
            r_pll_rst      <= 1'b1;
            r_ready        <= 1'b0;
        end
        else begin
            r_state        <= w_next;
            r_cnt          <= w_cnt;
            r_timeout_err  <= r_timeout_err | w_tmo;
            r_relock_count <= (w_relock && r_relock_count != 8'hFF) ? r_relock_count + 8'd1 : r_relock_count;
            r_pll_rst      <= (w_next == PLL_RST);
            r_ready        <= (w_next == RUN);
        end
    end
    assign bus.pll_rst      = r_pll_rst;
    assign bus.ready        = r_ready;
    assign bus.sys_rst      = ~r_ready;
    assign bus.timeout_err  = r_timeout_err;
    assign bus.relock_count = r_relock_count;
    assign bus.state        = r_state;
endmodule
